// File: rtl/poly_sub_q.sv
// Streaming coefficient-wise subtractor c[i] = (a[i] - b[i]) mod 3329 with a 2-stage valid/ready pipeline.
// Optional sticky input range error flag: define POLY_SUB_RANGE_CHECK_EN.
module poly_sub_q #(
   parameter int N_COEFF = 256,
   parameter int IDX_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [11:0]      in_a,
   input  logic [11:0]      in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [11:0]      out_coeff,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             err
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEFF - 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] cnt;
   logic             s1_v;
   logic [12:0]      s1_diff;
   logic [IDX_W-1:0] s1_idx;
   logic             s2_v;
   logic             done_set;
   logic             in_fire, out_fire, s1_adv, s2_adv;
   logic [11:0]      addback;

   assign s2_adv    = !s2_v || out_ready;
   assign s1_adv    = s1_v && s2_adv;
   assign out_valid = s2_v;
   assign out_fire  = s2_v && out_ready;
   assign in_fire   = in_valid && in_ready;

   // Only the low 12 bits of (diff + q) survive, so the add-back is done at 12 bits.
   assign addback = s1_diff[11:0] + 12'd3329;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      done_set  = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy     = 1'b1;
            in_ready = !s1_v || s1_adv;
            if (in_valid && in_ready && cnt == LAST_IDX) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (out_fire && out_last) begin
               state_nxt = IDLE;
               done_set  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         done  <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         done  <= done_set;
         if (state == IDLE && start) cnt <= '0;
         else if (in_fire)           cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v    <= 1'b0;
         s1_diff <= '0;
         s1_idx  <= '0;
      end else if (in_fire) begin
         s1_v    <= 1'b1;
         s1_diff <= {1'b0, in_a} - {1'b0, in_b};
         s1_idx  <= cnt;
      end else if (s1_adv) begin
         s1_v <= 1'b0;
      end
   end

   // Output registers only move when the downstream slot is free, keeping data stable under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_v      <= 1'b0;
         out_coeff <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
      end else if (s2_adv) begin
         s2_v <= s1_v;
         if (s1_v) begin
            out_coeff <= s1_diff[12] ? addback : s1_diff[11:0];
            out_idx   <= s1_idx;
            out_last  <= (s1_idx == LAST_IDX);
         end
      end
   end

`ifdef POLY_SUB_RANGE_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (state == IDLE && start) begin
         err <= 1'b0;
      end else if (in_fire && (in_a >= 12'd3329 || in_b >= 12'd3329)) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_poly_sub_q.sv
// Randomized self-checking bench for poly_sub_q against a queue-based reference model.
module tb_poly_sub_q;

   localparam int N = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy;
   logic        done;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_a;
   logic [11:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_coeff;
   logic [7:0]  out_idx;
   logic        out_last;
   logic        err;

   int total = 0;
   int bad   = 0;

   int qCoeff[$];
   int qIdx[$];
   bit qLast[$];
   int accepted = 0;
   bit mBusy = 1'b0;
   bit mDone = 1'b0;
   bit mErr  = 1'b0;
   bit lastInReady, lastOutValid;

   poly_sub_q #(.N_COEFF(N), .IDX_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_coeff(out_coeff),
      .out_idx(out_idx), .out_last(out_last), .err(err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, compare and update the model before the rising edge.
   task automatic applyStimulus(input bit v, input int a, input int b, input bit ordy, input bit st);
      bit inFire, outFire;
      int d;
      @(negedge clk);
      in_valid  = v;
      in_a      = 12'(a);
      in_b      = 12'(b);
      out_ready = ordy;
      start     = st;
      #1;
      checkOutput("done", 32'(done), 32'(mDone));
      checkOutput("busy", 32'(busy), 32'(mBusy));
      checkOutput("err", 32'(err), 32'(mErr));
      inFire       = in_valid && in_ready;
      outFire      = out_valid && out_ready;
      lastInReady  = in_ready;
      lastOutValid = out_valid;
      if (in_ready && !(mBusy && accepted < N))
         checkOutput("in_ready_when_not_accepting", 32'(in_ready), 32'd0);
      if (mBusy && accepted < N && qCoeff.size() == 0)
         checkOutput("in_ready_empty_pipe", 32'(in_ready), 32'd1);
      if (out_valid) begin
         if (qCoeff.size() == 0) begin
            checkOutput("spurious_out_valid", 32'(out_valid), 32'd0);
         end else begin
            checkOutput("out_coeff", 32'(out_coeff), 32'(qCoeff[0]));
            checkOutput("out_idx", 32'(out_idx), 32'(qIdx[0]));
            checkOutput("out_last", 32'(out_last), 32'(qLast[0]));
         end
      end
      mDone = outFire && qCoeff.size() > 0 && qLast[0];
      if (outFire && qCoeff.size() > 0) begin
         void'(qCoeff.pop_front());
         void'(qIdx.pop_front());
         void'(qLast.pop_front());
      end
      if (inFire) begin
         d = a - b;
         if (d < 0) d += 3329;
         qCoeff.push_back(d % 4096);
         qIdx.push_back(accepted % N);
         qLast.push_back((accepted % N) == N - 1);
         accepted++;
`ifdef POLY_SUB_RANGE_CHECK_EN
         if (a >= 3329 || b >= 3329) mErr = 1'b1;
`endif
      end
      if (st && !mBusy) begin
         mBusy    = 1'b1;
         accepted = 0;
         mErr     = 1'b0;
      end
      if (mDone) mBusy = 1'b0;
   endtask

   task automatic feed(input int stopAt, input int pv, input int pr, input int ps);
      for (int c = 0; c < 4000 && accepted < stopAt; c++)
         applyStimulus($urandom_range(99) < pv, $urandom_range(3328), $urandom_range(3328),
                       $urandom_range(99) < pr, $urandom_range(99) < ps);
      total++;
      assert (accepted >= stopAt) else begin
         bad++;
         $error("[TB] FAIL feed_timeout observed=%0d expected=%0d", accepted, stopAt);
      end
   endtask

   task automatic drain(input int pr, input int ps);
      for (int c = 0; c < 500 && mBusy; c++)
         applyStimulus(1'b1, $urandom_range(3328), $urandom_range(3328),
                       $urandom_range(99) < pr, $urandom_range(99) < ps);
      total++;
      assert (!mBusy) else begin
         bad++;
         $error("[TB] FAIL drain_timeout observed=%0d expected=%0d", mBusy, 0);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_coeff", 32'(out_coeff), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      rst = 1'b0;

      // Directed first pairs, then latency, then random completion of the job.
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
      applyStimulus(1'b1, 5, 10, 1'b1, 1'b0);
      checkOutput("first_accept", 32'(lastInReady), 32'd1);
      applyStimulus(1'b1, 3328, 0, 1'b1, 1'b0);
      checkOutput("latency_cycle1", 32'(lastOutValid), 32'd0);
      applyStimulus(1'b1, 0, 3328, 1'b1, 1'b0);
      checkOutput("latency_cycle2", 32'(lastOutValid), 32'd1);
      applyStimulus(1'b1, 1234, 1234, 1'b1, 1'b0);
      feed(N, 70, 70, 10);
      drain(70, 10);

      // Backpressure: five stalled cycles fill both stages and drop in_ready.
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
      feed(50, 80, 80, 10);
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, $urandom_range(3328), $urandom_range(3328), 1'b0, 1'b0);
      checkOutput("bp_in_ready", 32'(lastInReady), 32'd0);
      checkOutput("bp_out_valid", 32'(lastOutValid), 32'd1);
      feed(N, 100, 100, 10);
      drain(100, 10);

      // Asynchronous reset mid-job after 100 accepted pairs.
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
      feed(100, 90, 60, 0);
      @(negedge clk);
      in_valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      checkOutput("arst_busy", 32'(busy), 32'd0);
      checkOutput("arst_done", 32'(done), 32'd0);
      checkOutput("arst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("arst_out_coeff", 32'(out_coeff), 32'd0);
      checkOutput("arst_out_idx", 32'(out_idx), 32'd0);
      checkOutput("arst_out_last", 32'(out_last), 32'd0);
      checkOutput("arst_err", 32'(err), 32'd0);
      qCoeff.delete(); qIdx.delete(); qLast.delete();
      accepted = 0; mBusy = 1'b0; mDone = 1'b0; mErr = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1, 2, 1'b1, 1'b0);

      // Clean job led by an out-of-range pair; error state persists until the next honoured start.
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
      applyStimulus(1'b1, 3329, 0, 1'b1, 1'b0);
      feed(N, 75, 65, 10);
      drain(65, 10);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
      feed(N, 100, 100, 0);
      drain(100, 0);
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
